// File: rtl/my_alu.sv
// Registered ALU: unsigned/signed add and subtract, AND/OR/XOR, logical divide-by-two, plus carry/overflow/zero flags.
// Latency: 1 cycle from the input-sampling edge to result/flags; a new operation is accepted every cycle.
// Backpressure: none; the unit never stalls, and synchronous reset takes priority over the opcode.
module my_alu #(
  parameter int NUMBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic [2:0]         opcode,
  output logic [NUMBITS-1:0] result,
  output logic               carryout,
  output logic               overflow,
  output logic               zero
);

  localparam logic [2:0] OP_ADDU = 3'b000;
  localparam logic [2:0] OP_ADDS = 3'b001;
  localparam logic [2:0] OP_SUBU = 3'b010;
  localparam logic [2:0] OP_SUBS = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_DIV2 = 3'b111;

  localparam int MSB = NUMBITS - 1;

  logic [NUMBITS:0]   sum_ext;
  logic [NUMBITS:0]   diff_ext;
  logic               add_sovf;
  logic               sub_sovf;

  logic [NUMBITS-1:0] result_d, result_q;
  logic               carry_d, carry_q;
  logic               ovf_d, ovf_q;
  logic               zero_d, zero_q;

  // One adder and one subtractor shared by the signed and unsigned opcodes;
  // the extra top bit is the carry (add) or the borrow, i.e. A < B (subtract).
  always_comb begin
    sum_ext  = {1'b0, A} + {1'b0, B};
    diff_ext = {1'b0, A} - {1'b0, B};
    // Signed add overflows when like-signed operands yield a result of the other sign.
    add_sovf = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
    // Signed subtract overflows when operand signs differ and the result sign leaves A's.
    sub_sovf = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
  end

  // Opcode decode into next-state result and flags; zero is taken from the very value being registered.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    unique case (opcode)
      OP_ADDU: begin
        result_d = sum_ext[NUMBITS-1:0];
        carry_d  = sum_ext[NUMBITS];
        ovf_d    = sum_ext[NUMBITS];
      end
      OP_ADDS: begin
        result_d = sum_ext[NUMBITS-1:0];
        ovf_d    = add_sovf;
      end
      OP_SUBU: begin
        result_d = diff_ext[NUMBITS-1:0];
        carry_d  = diff_ext[NUMBITS];
        ovf_d    = diff_ext[NUMBITS];
      end
      OP_SUBS: begin
        result_d = diff_ext[NUMBITS-1:0];
        ovf_d    = sub_sovf;
      end
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_XOR:  result_d = A ^ B;
      OP_DIV2: result_d = {1'b0, A[NUMBITS-1:1]};
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  // Output register: reset forces an all-zero result with zero flag set, discarding any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign result   = result_q;
  assign carryout = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_my_alu.sv
// Bench for my_alu: integer-arithmetic reference model checked every cycle plus hand-computed vectors.
// Latency: expects each result one rising edge after its inputs were sampled.
// Backpressure: none; inputs are driven on falling edges, outputs sampled shortly after rising edges.
module tb_my_alu;

  localparam int  N    = 8;
  localparam longint FULL = 256;
  localparam longint HALF = 128;

  logic         clk;
  logic         reset;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   opcode;
  logic [N-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  my_alu #(.NUMBITS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .result   (result),
    .carryout (carryout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic.
  function automatic void model(input longint a, input longint b, input int op, input bit rst,
                                output longint r, output bit c, output bit o, output bit z);
    longint sa, sb, t;
    sa = (a >= HALF) ? a - FULL : a;
    sb = (b >= HALF) ? b - FULL : b;
    r = 0; c = 0; o = 0;
    if (rst) begin
      r = 0; c = 0; o = 0;
    end else begin
      case (op)
        0: begin t = a + b; r = t % FULL; c = (t >= FULL); o = c; end
        1: begin t = sa + sb; r = ((t % FULL) + FULL) % FULL; o = (t > HALF - 1) || (t < -HALF); end
        2: begin t = a - b; r = ((t % FULL) + FULL) % FULL; c = (a < b); o = c; end
        3: begin t = sa - sb; r = ((t % FULL) + FULL) % FULL; o = (t > HALF - 1) || (t < -HALF); end
        4: r = a & b;
        5: r = a | b;
        6: r = a ^ b;
        default: r = a / 2;
      endcase
    end
    z = (r == 0);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle compare: model the inputs present at the edge, compare just after it.
  initial begin
    longint er;
    bit ec, eo, ez;
    forever begin
      @(posedge clk);
      model(longint'(A), longint'(B), int'(opcode), reset, er, ec, eo, ez);
      #1;
      chk("model.result",   longint'(result),   er);
      chk("model.carryout", longint'(carryout), longint'(ec));
      chk("model.overflow", longint'(overflow), longint'(eo));
      chk("model.zero",     longint'(zero),     longint'(ez));
    end
  end

  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op, input logic rst);
    @(negedge clk);
    A = a; B = b; opcode = op; reset = rst;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [N-1:0] r, input logic c, input logic o, input logic z);
    chk({name, ".result"},   longint'(result),   longint'(r));
    chk({name, ".carryout"}, longint'(carryout), longint'(c));
    chk({name, ".overflow"}, longint'(overflow), longint'(o));
    chk({name, ".zero"},     longint'(zero),     longint'(z));
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic [N-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; A = 8'h55; B = 8'h33; opcode = 3'b000;

    // Reset with live operands present.
    step(8'h55, 8'h33, 3'b000, 1'b1);
    lit("reset", 8'h00, 1'b0, 1'b0, 1'b1);

    // Directed vectors, applied back to back with a different opcode each cycle.
    vecs.push_back('{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{8'h0A, 8'h11, 3'b000, 8'h1B, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'hB1, 8'h20, 3'b010, 8'h91, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h20, 8'hB1, 3'b010, 8'h6F, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{8'h55, 8'hF6, 3'b001, 8'h4B, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 3'b001, 8'h80, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'hF5, 8'h19, 3'b011, 8'hDC, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 3'b011, 8'h7F, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'h00, 3'b100, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'hAA, 8'hD7, 3'b101, 8'hFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h0F, 8'hF0, 3'b110, 8'hFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h1A, 8'hFF, 3'b111, 8'h0D, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'hA5, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 3'b001, 8'h00, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{8'h3C, 8'h3C, 3'b010, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h7F, 8'hFF, 3'b011, 8'h80, 1'b0, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
      lit($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].z);
    end

    // Inputs changed between edges must not disturb the held outputs.
    step(8'h0A, 8'h11, 3'b000, 1'b0);
    lit("hold.before", 8'h1B, 1'b0, 1'b0, 1'b0);
    #1;
    A = 8'hFF; B = 8'hFF; opcode = 3'b010;
    #1;
    lit("hold.after", 8'h1B, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    lit("hold.next", 8'h00, 1'b0, 1'b0, 1'b1);

    // Mid-stream reset discards the operation, then the first released edge computes.
    step(8'h7F, 8'h01, 3'b001, 1'b1);
    lit("midreset", 8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h7F, 8'h01, 3'b001, 1'b0);
    lit("release", 8'h80, 1'b0, 1'b1, 1'b0);

    // Sweep every opcode over a few operand pairs; the every-cycle compare checks these.
    for (int op = 0; op < 8; op++) begin
      step(8'hC3, 8'h5A, 3'(op), 1'b0);
      step(8'h00, 8'h00, 3'(op), 1'b0);
      step(8'h81, 8'h7F, 3'(op), 1'b0);
      step(8'h7E, 8'h81, 3'(op), 1'b0);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
